// File: rtl/nios_system_input_debounce_pkg.sv
// Shared constants and helpers for the input debounce stage.
package nios_system_input_debounce_pkg;

    // 1 ms of stable input at a 50 MHz system clock.
    localparam int unsigned NIOS_DEBOUNCE_1MS_50MHZ = 50000;

    // Ceiling log2; returns 0 for values of 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter width for a given debounce interval, never less than one bit.
    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        return (clog2(cycles) < 1) ? 1 : clog2(cycles);
    endfunction

endpackage

// File: rtl/nios_system_input_debounce_bit.sv
// Single-bit synchroniser, debounce counter, stable register and edge strobes.
//
// Per-bit behaviour (derived from cnt and the sync2/stable comparison):
//   state   | meaning
//   IDLE    | sync2 == stable, cnt held at 0
//   PENDING | sync2 != stable, counting consecutive mismatching cycles
// When the count completes, stable takes the new level, cnt returns to 0
// and a one-cycle rise or fall strobe is registered alongside the change.
module nios_system_debounce_bit
    import nios_system_input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = NIOS_DEBOUNCE_1MS_50MHZ,
    parameter logic        INIT_VALUE      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_next
);

    localparam int unsigned      CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic             sync1_q;
    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic             sync2_q;
    logic             sync1_d, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state: resync the raw level, count mismatches, commit on terminal count.
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset wins and abandons any count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= INIT_VALUE;
            sync2_q  <= INIT_VALUE;
            stable_q <= INIT_VALUE;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_out  = stable_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    // Lets the parent register an aggregate strobe in the same cycle as ours.
    assign change_next = rise_d | fall_d;

endmodule

// File: rtl/nios_system_input_debounce.sv
// Debounce stage in front of the PIO input slave: WIDTH independent bits
// plus an aggregate change strobe for edge-capture/interrupt logic.
module nios_system_input_debounce
    import nios_system_input_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = NIOS_DEBOUNCE_1MS_50MHZ,
    parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    logic [WIDTH-1:0] change_next;
    logic             any_change_q, any_change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_system_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_VALUE      (INIT_VALUE[i])
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .raw_in      (raw_in[i]),
            .stable_out  (debounced_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .change_next (change_next[i])
        );
    end

    // Aggregate of the per-bit strobes that will be registered this edge.
    always_comb begin
        any_change_d = |change_next;
    end

    // Registered so any_change lines up with the per-bit strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_nios_system_input_debounce.sv
// Directed scoreboard bench: two instances (INIT 0x00 and 0xFF), DEBOUNCE_CYCLES=4.
module tb_nios_system_input_debounce;

    typedef struct packed {
        logic       sel;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] raw0, raw1;
    logic [7:0] out0, rise0, fall0, out1, rise1, fall1;
    logic       any0, any1;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    nios_system_input_debounce #(
        .WIDTH (8), .DEBOUNCE_CYCLES (4), .INIT_VALUE (8'h00)
    ) dut0 (
        .clk (clk), .reset (reset), .raw_in (raw0), .debounced_out (out0),
        .rise_pulse (rise0), .fall_pulse (fall0), .any_change (any0)
    );

    nios_system_input_debounce #(
        .WIDTH (8), .DEBOUNCE_CYCLES (4), .INIT_VALUE (8'hFF)
    ) dut1 (
        .clk (clk), .reset (reset), .raw_in (raw1), .debounced_out (out1),
        .rise_pulse (rise1), .fall_pulse (fall1), .any_change (any1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later and compare against the scoreboard.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 1'b0) begin
                chk("dut0.debounced_out", out0, e.out);
                chk("dut0.rise_pulse", rise0, e.rise);
                chk("dut0.fall_pulse", fall0, e.fall);
                chk("dut0.any_change", {7'd0, any0}, {7'd0, |(e.rise | e.fall)});
            end else begin
                chk("dut1.debounced_out", out1, e.out);
                chk("dut1.rise_pulse", rise1, e.rise);
                chk("dut1.fall_pulse", fall1, e.fall);
                chk("dut1.any_change", {7'd0, any1}, {7'd0, |(e.rise | e.fall)});
            end
        end
    endtask

    task automatic run(input int n, input logic sel, input logic [7:0] o,
                       input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.sel  = sel;
        e.out  = o;
        e.rise = r;
        e.fall = f;
        for (int i = 0; i < n; i++) sb.push_back(e);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1;
        raw0  = 8'h00;
        raw1  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: output at INIT, no strobes.
        run(20, 1'b0, 8'h00, 8'h00, 8'h00);

        // Held 0x00 -> 0x01: change lands on edge 6.
        raw0 = 8'h01;
        run(5, 1'b0, 8'h00, 8'h00, 8'h00);
        run(1, 1'b0, 8'h01, 8'h01, 8'h00);
        run(3, 1'b0, 8'h01, 8'h00, 8'h00);

        // Bit 3 bounces every 2 cycles, then holds high.
        raw0 = 8'h09; run(2, 1'b0, 8'h01, 8'h00, 8'h00);
        raw0 = 8'h01; run(2, 1'b0, 8'h01, 8'h00, 8'h00);
        raw0 = 8'h09; run(2, 1'b0, 8'h01, 8'h00, 8'h00);
        raw0 = 8'h01; run(2, 1'b0, 8'h01, 8'h00, 8'h00);
        raw0 = 8'h09;
        run(5, 1'b0, 8'h01, 8'h00, 8'h00);
        run(1, 1'b0, 8'h09, 8'h08, 8'h00);
        run(3, 1'b0, 8'h09, 8'h00, 8'h00);

        // 3-cycle glitch on bit 7: one short of the interval, never reaches output.
        raw0 = 8'h89; run(3, 1'b0, 8'h09, 8'h00, 8'h00);
        raw0 = 8'h09; run(12, 1'b0, 8'h09, 8'h00, 8'h00);

        // Active-low style instance: 0xFF -> 0xF0 gives fall strobes on low nibble.
        raw1 = 8'hF0;
        run(5, 1'b1, 8'hFF, 8'h00, 8'h00);
        run(1, 1'b1, 8'hF0, 8'h00, 8'h0F);
        run(3, 1'b1, 8'hF0, 8'h00, 8'h00);

        // Reset drops 0x09 to INIT without a fall strobe.
        reset = 1'b1;
        raw0  = 8'h00;
        run(3, 1'b0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        run(3, 1'b0, 8'h00, 8'h00, 8'h00);

        // Reset hits edges 4 and 5 of a 0x00 -> 0x01 transition; full interval restarts.
        raw0 = 8'h01;
        run(3, 1'b0, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        run(2, 1'b0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        run(5, 1'b0, 8'h00, 8'h00, 8'h00);
        run(1, 1'b0, 8'h01, 8'h01, 8'h00);
        run(3, 1'b0, 8'h01, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
